// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory with fixed multi-cycle access latency.
// Stalls the pipeline while an access is in flight and flags misaligned words.
module mem_stage_dmem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128,
    parameter int LAT    = 2
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic [31:0]       addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              stall_o,
    output logic              misalign_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LAT) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               mis_q, mis_d;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               req;
    logic               mis_addr;
    logic               commit;
    logic               stall;
    logic [IDX_W-1:0]   idx;
    logic [DATA_W-1:0]  rd_word;
    logic               unused_addr;

    assign req         = memread_i | memwrite_i;
    assign mis_addr    = addr_i[1:0] != 2'b00;
    assign idx         = addr_i[IDX_W+1:2];
    assign rd_word     = mem[idx];
    assign unused_addr = ^addr_i[31:IDX_W+2];

    // commit is high in the cycle whose closing edge enters DONE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = req;
                cnt_d = '0;
                if (req) begin
                    cnt_d = CNT_W'(1);
                    if (LAT == 1) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(LAT - 1)) begin
                    state_d = DONE;
                    commit  = 1'b1;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        if (commit) begin
            if (mis_addr) begin
                rdata_d = '0;
                mis_d   = 1'b1;
            end else if (memread_i) begin
                rdata_d = rd_word;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
        end
    end

    // Array is deliberately left out of reset; read-before-write comes for free
    always_ff @(posedge clk_i) begin
        if (commit && memwrite_i && !mis_addr) begin
            mem[idx] <= wdata_i;
        end
    end

    assign stall_o    = stall & rst_n;
    assign rdata_o    = rdata_q;
    assign misalign_o = mis_q;

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Scoreboard bench for mem_stage_dmem: latency, wrap, misalign,
// read-before-write, mid-access reset and back-to-back stall pattern.
module tb_mem_stage_dmem;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 128;
    localparam int LAT    = 2;

    logic              clk_i = 1'b0;
    logic              rst_n = 1'b0;
    logic              memread_i = 1'b0;
    logic              memwrite_i = 1'b0;
    logic [31:0]       addr_i = '0;
    logic [DATA_W-1:0] wdata_i = '0;
    logic [DATA_W-1:0] rdata_o;
    logic              stall_o;
    logic              misalign_o;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        logic              mis;
        string             name;
    } exp_t;

    exp_t              sb[$];
    logic [DATA_W-1:0] mdl [int];
    logic [DATA_W-1:0] rd_model = '0;
    int                vectors = 0;
    int                errors  = 0;

    mem_stage_dmem #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .LAT   (LAT)
    ) dut (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .memread_i (memread_i),
        .memwrite_i(memwrite_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .rdata_o   (rdata_o),
        .stall_o   (stall_o),
        .misalign_o(misalign_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // Model the request and queue what the DONE cycle should show
    task automatic push_exp(input logic rd, input logic wr,
                            input logic [31:0] a,
                            input logic [DATA_W-1:0] wd,
                            input string nm);
        exp_t e;
        int   i;
        i = widx(a);
        e.name = nm;
        e.mis  = (a[1:0] != 2'b00);
        if (e.mis) e.rdata = '0;
        else if (rd) e.rdata = mdl.exists(i) ? mdl[i] : 'x;
        else e.rdata = rd_model;
        rd_model = e.rdata;
        if (wr && !e.mis) mdl[i] = wd;
        sb.push_back(e);
    endtask

    task automatic check_done(input int st);
        exp_t e;
        vectors++;
        if (st != LAT) begin
            errors++;
            $display("FAIL stall_len: got %0d cycles, want %0d", st, LAT);
        end
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: empty at DONE, want 1 entry");
            return;
        end
        e = sb.pop_front();
        vectors++;
        if (rdata_o !== e.rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h, want %h", e.name, rdata_o, e.rdata);
        end
        vectors++;
        if (misalign_o !== e.mis) begin
            errors++;
            $display("FAIL %s misalign: got %b, want %b", e.name, misalign_o, e.mis);
        end
    endtask

    // Called just after a posedge; returns just after the edge leaving DONE
    task automatic access(input logic rd, input logic wr,
                          input logic [31:0] a,
                          input logic [DATA_W-1:0] wd,
                          input string nm);
        int st;
        push_exp(rd, wr, a, wd, nm);
        memread_i  = rd;
        memwrite_i = wr;
        addr_i     = a;
        wdata_i    = wd;
        st = 0;
        @(negedge clk_i);
        while (stall_o !== 1'b0 && st < 20) begin
            st++;
            @(negedge clk_i);
        end
        check_done(st);
        @(posedge clk_i);
        #1;
        memread_i  = 1'b0;
        memwrite_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        memread_i = 1'b1;
        #12;
        vectors++;
        if (stall_o !== 1'b0 || rdata_o !== '0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL reset: got stall=%b rdata=%h mis=%b, want 0/0/0",
                     stall_o, rdata_o, misalign_o);
        end
        memread_i = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;
        rd_model = '0;
    endtask

    task automatic test_store_load();
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "store_10");
        access(1'b1, 1'b0, 32'h10, 32'h0, "load_10");
    endtask

    task automatic test_wrap();
        access(1'b0, 1'b1, 32'h004, 32'h12345678, "store_004");
        access(1'b1, 1'b0, 32'h204, 32'h0, "load_204_wrap");
    endtask

    task automatic test_misalign();
        access(1'b0, 1'b1, 32'h13, 32'hAAAA5555, "store_13_mis");
        @(negedge clk_i);
        vectors++;
        if (misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL mis_pulse: got %b after DONE, want 0", misalign_o);
        end
        @(posedge clk_i);
        #1;
        access(1'b1, 1'b0, 32'h10, 32'h0, "load_10_after_mis");
    endtask

    task automatic test_rbw();
        access(1'b0, 1'b1, 32'h20, 32'h11111111, "store_20");
        access(1'b1, 1'b1, 32'h20, 32'h22222222, "rw_20");
        access(1'b1, 1'b0, 32'h20, 32'h0, "load_20");
    endtask

    task automatic test_reset_mid();
        access(1'b0, 1'b1, 32'h40, 32'h0BADF00D, "store_40_old");
        access(1'b1, 1'b0, 32'h20, 32'h0, "load_20_nz");
        memwrite_i = 1'b1;
        addr_i     = 32'h40;
        wdata_i    = 32'h55;
        @(posedge clk_i);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (stall_o !== 1'b0 || rdata_o !== '0 || misalign_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got stall=%b rdata=%h mis=%b, want 0/0/0",
                     stall_o, rdata_o, misalign_o);
        end
        rd_model   = '0;
        memwrite_i = 1'b0;
        @(negedge clk_i);
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;
        access(1'b1, 1'b0, 32'h40, 32'h0, "load_40_after_rst");
    endtask

    task automatic test_back_to_back();
        logic [6:0]  want_rd;
        logic [6:0]  got;
        logic [6:0]  want;
        logic [31:0] adr [7];
        want_rd = 7'b0111111;
        want    = 7'b0011011;
        adr = '{32'h10, 32'h10, 32'h10, 32'h20, 32'h20, 32'h20, 32'h0};
        got = '0;
        for (int c = 0; c < 7; c++) begin
            memread_i  = want_rd[c];
            memwrite_i = 1'b0;
            addr_i     = adr[c];
            if (c == 0) push_exp(1'b1, 1'b0, adr[c], '0, "b2b_load_a");
            if (c == 3) push_exp(1'b1, 1'b0, adr[c], '0, "b2b_load_b");
            @(negedge clk_i);
            got[c] = stall_o;
            if (c == 2 || c == 5) check_done(LAT);
            @(posedge clk_i);
            #1;
        end
        memread_i = 1'b0;
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL b2b_stall: got %b, want %b (bit0=cycle0)", got, want);
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_wrap();
        test_misalign();
        test_rbw();
        test_reset_mid();
        test_back_to_back();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
